// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding, width helpers and invalid-result markers for the arithmetic blocks
package arith_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam logic [63:0] INVALID = '1;
    function automatic int qw_of(input int w);
        return w / 2;
    endfunction
    function automatic int mw_of(input int w);
        return w / 2 + 1;
    endfunction
endpackage

// File: rtl/isqrt_seq_if.sv
// isqrt_seq_if: start/busy/done handshake and operand/result bus; chk_err exists only with ISQRT_SELFCHECK_EN
interface isqrt_seq_if
    import arith_pkg::*;
#(parameter int W = 20);
    localparam int QW = qw_of(W);
    localparam int MW = mw_of(W);
    logic start;
    logic [W-1:0] a;
    logic busy;
    logic done;
    logic [QW-1:0] q;
    logic [MW-1:0] m;
`ifdef ISQRT_SELFCHECK_EN
    logic chk_err;
    modport master(output start, a, input busy, done, q, m, chk_err);
    modport slave(input start, a, output busy, done, q, m, chk_err);
`else
    modport master(output start, a, input busy, done, q, m);
    modport slave(input start, a, output busy, done, q, m);
`endif
endinterface

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational restoring square-root iteration consuming two radicand bits
module isqrt_step #(
    parameter int QW = 10
) (
    input  logic [QW+1:0] rem_i,
    input  logic [QW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [QW+1:0] rem_o,
    output logic [QW-1:0] root_o
);
    logic [QW+1:0] rem_sh;
    logic [QW+1:0] trial;
    logic ge;
    // shift in the next radicand pair, try subtracting 4*root+1
    always_comb begin
        rem_sh = {rem_i[QW-1:0], bits_i};
        trial = {root_i, 2'b01};
        ge = rem_sh >= trial;
        rem_o = ge ? rem_sh - trial : rem_sh;
        root_o = {root_i[QW-2:0], ge};
    end
endmodule

// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential bit-by-bit integer square root, one root bit per clock; optional ISQRT_SELFCHECK_EN adds chk_err
module isqrt_seq
    import arith_pkg::*;
#(
    parameter int W = 20
) (
    input logic        t,
    input logic        rn,
    isqrt_seq_if.slave bus
);
    localparam int QW = qw_of(W);
    localparam int MW = mw_of(W);
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;
    state_t state_q;
    logic [W-1:0] s_q;
    logic [MW:0] rem_q, rem_d;
    logic [QW-1:0] root_q, root_d, q_q;
    logic [MW-1:0] m_q;
    logic [CW-1:0] cnt_q;
    logic busy_q, done_q;
    isqrt_step #(.QW(QW)) u_step (
        .rem_i (rem_q),
        .root_i(root_q),
        .bits_i(s_q[W-1 -: 2]),
        .rem_o (rem_d),
        .root_o(root_d)
    );
    // control FSM: capture on start, iterate QW times, publish result with a one-cycle done
    always_ff @(posedge t) begin
        if (!rn) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            q_q <= INVALID[QW-1:0];
            m_q <= INVALID[MW-1:0];
            cnt_q <= '0;
            s_q <= '0;
            rem_q <= '0;
            root_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        s_q <= bus.a;
                        rem_q <= '0;
                        root_q <= '0;
                        cnt_q <= CW'(QW - 1);
                        busy_q <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    s_q <= {s_q[W-3:0], 2'b00};
                    rem_q <= rem_d;
                    root_q <= root_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        q_q <= root_d;
                        m_q <= rem_d[MW-1:0];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q = q_q;
    assign bus.m = m_q;
`ifdef ISQRT_SELFCHECK_EN
    logic [W-1:0] a_q;
    logic chk_q;
    logic [W:0] recon;
    logic [MW-1:0] m_fin;
    // rebuild q*q+m from the final iteration's outputs so chk_err is valid alongside done
    always_comb begin
        m_fin = rem_d[MW-1:0];
        recon = (W+1)'(root_d) * (W+1)'(root_d) + (W+1)'(m_fin);
    end
    // retain the accepted radicand and register the consistency verdict at completion
    always_ff @(posedge t) begin
        if (!rn) begin
            a_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) a_q <= bus.a;
            if (state_q == CALC && cnt_q == '0) chk_q <= (recon != {1'b0, a_q}) || (m_fin > {root_d, 1'b0});
        end
    end
    assign bus.chk_err = chk_q;
`endif
endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: scoreboard bench for isqrt_seq; expected results queued at issue, checked by a done monitor
module tb_isqrt_seq;
    localparam int W = 20;
    localparam int QW = 10;
    typedef struct {
        int q;
        int m;
        int due;
    } exp_t;
    logic t = 1'b0;
    logic rn = 1'b0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];
    isqrt_seq_if #(.W(W)) bus ();
    isqrt_seq #(.W(W)) dut (
        .t  (t),
        .rn (rn),
        .bus(bus)
    );
    always #5 t = ~t;
    always @(posedge t) cyc <= cyc + 1;
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge t);
            n++;
        end
        if (n >= 100) timeout("wait_idle");
    endtask
    task automatic run_op(input int a, input int eq, input int em);
        wait_idle();
        bus.a = W'(a);
        bus.start = 1'b1;
        sb.push_back('{eq, em, cyc + 1 + QW});
        @(negedge t);
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
    endtask
    // monitor: every done pulse must match the oldest outstanding expectation, on time
    initial begin
        exp_t e;
        forever begin
            @(negedge t);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    chk("q", int'(bus.q), e.q);
                    chk("m", int'(bus.m), e.m);
                    chk("done_latency", cyc, e.due);
`ifdef ISQRT_SELFCHECK_EN
                    chk("chk_err", int'(bus.chk_err), 0);
`endif
                end
            end
        end
    end
    initial begin
        int n;
        int a;
        int r;
        bus.start = 1'b0;
        bus.a = '0;
        repeat (2) @(negedge t);
        rn = 1'b1;
        @(negedge t);
        chk("rst_q", int'(bus.q), 1023);
        chk("rst_m", int'(bus.m), 2047);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
`ifdef ISQRT_SELFCHECK_EN
        chk("rst_chk_err", int'(bus.chk_err), 0);
`endif
        run_op(72897, 269, 536);
        repeat (3) @(negedge t);
        chk("q_held_in_calc", int'(bus.q), 1023);
        run_op(0, 0, 0);
        run_op(1, 1, 0);
        run_op(72900, 270, 0);
        run_op(1048575, 1023, 2046);
        wait_idle();
        bus.a = 20'd40000;
        bus.start = 1'b1;
        sb.push_back('{200, 0, cyc + 1 + QW});
        repeat (4) @(negedge t);
        bus.a = 20'd99;
        chk("q_held_prev", int'(bus.q), 1023);
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge t);
            n++;
        end
        if (n >= 50) timeout("held_start_done");
        bus.a = 20'd10000;
        sb.push_back('{100, 0, cyc + 2 + QW});
        @(negedge t);
        chk("idle_after_done_busy", int'(bus.busy), 0);
        @(negedge t);
        bus.start = 1'b0;
        chk("busy_second_op", int'(bus.busy), 1);
        wait_idle();
        bus.a = 20'd72897;
        bus.start = 1'b1;
        @(negedge t);
        bus.start = 1'b0;
        repeat (4) @(negedge t);
        rn = 1'b0;
        @(negedge t);
        rn = 1'b1;
        chk("abort_q", int'(bus.q), 1023);
        chk("abort_m", int'(bus.m), 2047);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (15) @(negedge t);
        run_op(144, 12, 0);
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            r = 0;
            while ((r + 1) * (r + 1) <= a) r++;
            run_op(a, r, a - r * r);
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge t);
            n++;
        end
        if (sb.size() != 0) timeout("drain");
        repeat (3) @(negedge t);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
